// File: rtl/conv_core_seq.sv
// conv_core_seq: per-core operand buffers plus the oc/oy/ox/ky/kx walk that
// streams (act, weight) beats to the MAC array, one IC slice per run.
// Optional feature macro: PERF_CNT_EN adds the perf_stall_cnt output
// (cycles with mac_valid && !mac_ready, cleared on accepted start, saturating).
//
// Handshake: a beat transfers on a rising edge where mac_valid && mac_ready.
// While mac_valid is high and mac_ready is low every mac_* output holds and
// the loop counters freeze; mac_valid only falls after a transfer.
module conv_core_seq #(
  parameter int ACT_PER_CORE    = 13,
  parameter int WEIGHT_PER_CORE = 10,
  parameter int INPUT_BW        = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [9:0]                 TOTAL_IC,
  input  logic [7:0]                 OC,
  input  logic [5:0]                 IMG_H,
  input  logic [5:0]                 IMG_W,
  input  logic [2:0]                 K,
  input  logic [2:0]                 STRIDE,
  input  logic                       act_wr_en,
  input  logic [ACT_PER_CORE-1:0]    act_wr_addr,
  input  logic [INPUT_BW-1:0]        act_wr_data,
  input  logic                       wgt_wr_en,
  input  logic [WEIGHT_PER_CORE-1:0] wgt_wr_addr,
  input  logic [INPUT_BW-1:0]        wgt_wr_data,
  input  logic                       core_start,
  output logic                       core_done,
  output logic                       busy,
  output logic                       mac_valid,
  input  logic                       mac_ready,
  output logic [INPUT_BW-1:0]        mac_act,
  output logic [INPUT_BW-1:0]        mac_wgt,
  output logic                       mac_first,
  output logic                       mac_last,
  output logic [7:0]                 mac_oc,
  output logic [5:0]                 mac_oy,
  output logic [5:0]                 mac_ox,
  output logic [1:0]                 dbg_state,
  output logic [9:0]                 dbg_total_ic
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]                perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t state;

  // Configuration captured on the accepted start.
  logic [9:0] cfg_ic;
  logic [7:0] cfg_oc;
  logic [5:0] cfg_h;
  logic [5:0] cfg_w;
  logic [2:0] cfg_k;
  logic [2:0] cfg_s;

  // Loop counters of the beat currently being issued.
  logic [7:0] oc_c;
  logic [5:0] oy_c;
  logic [5:0] ox_c;
  logic [2:0] ky_c;
  logic [2:0] kx_c;

  logic iss_done;   // every beat of the run has been issued
  logic mac_final;  // beat on the output is the last one of the run

  logic [INPUT_BW-1:0] act_mem [0:(1<<ACT_PER_CORE)-1];
  logic [INPUT_BW-1:0] wgt_mem [0:(1<<WEIGHT_PER_CORE)-1];

  logic [6:0]                 in_w;
  logic [ACT_PER_CORE-1:0]    act_addr;
  logic [WEIGHT_PER_CORE-1:0] wgt_addr;
  logic cfg_zero, advance, issue, xfer;
  logic kx_wrap, ky_wrap, ox_wrap, oy_wrap, oc_wrap, beat_final;

  assign dbg_state    = state;
  assign dbg_total_ic = cfg_ic;

  // Issue control, loop wrap detection and operand address generation.
  always_comb begin
    cfg_zero   = (cfg_oc == 8'd0) || (cfg_h == 6'd0) || (cfg_w == 6'd0) || (cfg_k == 3'd0);
    advance    = !mac_valid || mac_ready;
    issue      = (state == S_RUN) && !cfg_zero && !iss_done && advance;
    xfer       = mac_valid && mac_ready;
    kx_wrap    = (kx_c == cfg_k - 3'd1);
    ky_wrap    = (ky_c == cfg_k - 3'd1);
    ox_wrap    = (ox_c == cfg_w - 6'd1);
    oy_wrap    = (oy_c == cfg_h - 6'd1);
    oc_wrap    = (oc_c == cfg_oc - 8'd1);
    beat_final = kx_wrap && ky_wrap && ox_wrap && oy_wrap && oc_wrap;
    in_w       = 7'((7'(cfg_w) - 7'd1) * 7'(cfg_s) + 7'(cfg_k));
    act_addr   = ACT_PER_CORE'((17'(oy_c) * 17'(cfg_s) + 17'(ky_c)) * 17'(in_w)
                               + 17'(ox_c) * 17'(cfg_s) + 17'(kx_c));
    wgt_addr   = WEIGHT_PER_CORE'(16'(oc_c) * 16'(cfg_k) * 16'(cfg_k)
                                  + 16'(ky_c) * 16'(cfg_k) + 16'(kx_c));
  end

  // Buffer writes; only accepted while idle so a running stream sees stable data.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && act_wr_en) act_mem[act_wr_addr] <= act_wr_data;
    if (state == S_IDLE && wgt_wr_en) wgt_mem[wgt_wr_addr] <= wgt_wr_data;
  end

  // Sequencer FSM: config capture, loop counters and the registered beat stage.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      core_done <= 1'b0;
      cfg_ic    <= '0;
      cfg_oc    <= '0;
      cfg_h     <= '0;
      cfg_w     <= '0;
      cfg_k     <= '0;
      cfg_s     <= '0;
      oc_c      <= '0;
      oy_c      <= '0;
      ox_c      <= '0;
      ky_c      <= '0;
      kx_c      <= '0;
      iss_done  <= 1'b0;
      mac_valid <= 1'b0;
      mac_act   <= '0;
      mac_wgt   <= '0;
      mac_first <= 1'b0;
      mac_last  <= 1'b0;
      mac_oc    <= '0;
      mac_oy    <= '0;
      mac_ox    <= '0;
      mac_final <= 1'b0;
    end else begin
      core_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (core_start) begin
            state    <= S_RUN;
            busy     <= 1'b1;
            cfg_ic   <= TOTAL_IC;
            cfg_oc   <= OC;
            cfg_h    <= IMG_H;
            cfg_w    <= IMG_W;
            cfg_k    <= K;
            cfg_s    <= STRIDE;
            oc_c     <= '0;
            oy_c     <= '0;
            ox_c     <= '0;
            ky_c     <= '0;
            kx_c     <= '0;
            iss_done <= 1'b0;
          end
        end
        S_RUN: begin
          if (cfg_zero) begin
            // Degenerate shape: nothing to stream.
            state     <= S_FIN;
            core_done <= 1'b1;
          end else begin
            if (issue) begin
              iss_done <= beat_final;
              if (!kx_wrap) begin
                kx_c <= kx_c + 3'd1;
              end else begin
                kx_c <= '0;
                if (!ky_wrap) begin
                  ky_c <= ky_c + 3'd1;
                end else begin
                  ky_c <= '0;
                  if (!ox_wrap) begin
                    ox_c <= ox_c + 6'd1;
                  end else begin
                    ox_c <= '0;
                    if (!oy_wrap) begin
                      oy_c <= oy_c + 6'd1;
                    end else begin
                      oy_c <= '0;
                      oc_c <= oc_wrap ? 8'd0 : oc_c + 8'd1;
                    end
                  end
                end
              end
            end
            // Buffer read data and the beat's tags land together.
            if (advance) begin
              mac_valid <= issue;
              mac_act   <= act_mem[act_addr];
              mac_wgt   <= wgt_mem[wgt_addr];
              mac_first <= (ky_c == 3'd0) && (kx_c == 3'd0);
              mac_last  <= kx_wrap && ky_wrap;
              mac_oc    <= oc_c;
              mac_oy    <= oy_c;
              mac_ox    <= ox_c;
              mac_final <= beat_final;
            end
            if (xfer && mac_final) begin
              state     <= S_FIN;
              core_done <= 1'b1;
              mac_valid <= 1'b0;
            end
          end
        end
        S_FIN: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef PERF_CNT_EN
  // Backpressure cycles of the current run, saturating at all-ones.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_stall_cnt <= '0;
    end else if (state == S_IDLE && core_start) begin
      perf_stall_cnt <= '0;
    end else if (mac_valid && !mac_ready && perf_stall_cnt != 32'hFFFF_FFFF) begin
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_core_seq.sv
// Bench for conv_core_seq: directed shapes, backpressure, ignored start/writes,
// degenerate shapes, mid-run reset and randomized shapes against a loop model.
`timescale 1ns/1ps
module tb_conv_core_seq;
  localparam int AW = 13;
  localparam int WW = 10;
  localparam int BW = 8;
  localparam int PW = 38;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [9:0]    TOTAL_IC = '0;
  logic [7:0]    OC = '0;
  logic [5:0]    IMG_H = '0;
  logic [5:0]    IMG_W = '0;
  logic [2:0]    K = '0;
  logic [2:0]    STRIDE = '0;
  logic          act_wr_en = 1'b0;
  logic [AW-1:0] act_wr_addr = '0;
  logic [BW-1:0] act_wr_data = '0;
  logic          wgt_wr_en = 1'b0;
  logic [WW-1:0] wgt_wr_addr = '0;
  logic [BW-1:0] wgt_wr_data = '0;
  logic          core_start = 1'b0;
  logic          mac_ready = 1'b1;
  logic          core_done, busy, mac_valid, mac_first, mac_last;
  logic [BW-1:0] mac_act, mac_wgt;
  logic [7:0]    mac_oc;
  logic [5:0]    mac_oy, mac_ox;
  logic [1:0]    dbg_state;
  logic [9:0]    dbg_total_ic;
`ifdef PERF_CNT_EN
  logic [31:0]   perf_stall_cnt;
`endif

  conv_core_seq dut (
    .clk(clk), .resetn(resetn),
    .TOTAL_IC(TOTAL_IC), .OC(OC), .IMG_H(IMG_H), .IMG_W(IMG_W), .K(K), .STRIDE(STRIDE),
    .act_wr_en(act_wr_en), .act_wr_addr(act_wr_addr), .act_wr_data(act_wr_data),
    .wgt_wr_en(wgt_wr_en), .wgt_wr_addr(wgt_wr_addr), .wgt_wr_data(wgt_wr_data),
    .core_start(core_start), .core_done(core_done), .busy(busy),
    .mac_valid(mac_valid), .mac_ready(mac_ready),
    .mac_act(mac_act), .mac_wgt(mac_wgt), .mac_first(mac_first), .mac_last(mac_last),
    .mac_oc(mac_oc), .mac_oy(mac_oy), .mac_ox(mac_ox),
    .dbg_state(dbg_state), .dbg_total_ic(dbg_total_ic)
`ifdef PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [BW-1:0] act_m [0:(1<<AW)-1];
  logic [BW-1:0] wgt_m [0:(1<<WW)-1];
  logic [PW-1:0] exp_q[$];

  // Expected beat list straight from the loop-nest definition.
  task automatic build_exp(input int oc, input int h, input int w, input int k, input int s);
    int in_w, aa, wa;
    exp_q.delete();
    in_w = ((w - 1) * s + k) & 127;
    for (int o = 0; o < oc; o++)
      for (int y = 0; y < h; y++)
        for (int x = 0; x < w; x++)
          for (int ky = 0; ky < k; ky++)
            for (int kx = 0; kx < k; kx++) begin
              aa = ((y * s + ky) * in_w + x * s + kx) & ((1 << AW) - 1);
              wa = (o * k * k + ky * k + kx) & ((1 << WW) - 1);
              exp_q.push_back({act_m[aa], wgt_m[wa], (ky == 0 && kx == 0),
                               (ky == k - 1 && kx == k - 1), o[7:0], y[5:0], x[5:0]});
            end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int beat_cnt = 0;
  int done_cnt = 0;
  int first_valid_cyc = -1;
  int last_xfer_cyc = -1;
  int done_cyc = -1;
  logic hold_pend = 1'b0;
  logic [PW:0] held = '0;
  wire [PW-1:0] cur = {mac_act, mac_wgt, mac_first, mac_last, mac_oc, mac_oy, mac_ox};

  always @(negedge clk) begin
    if (resetn) begin
      if (hold_pend) check("hold_stable", {mac_valid, cur}, held);
      hold_pend = mac_valid && !mac_ready;
      held = {mac_valid, cur};
      if (mac_valid) begin
        check("valid_while_busy", busy, 1);
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (mac_valid && mac_ready) begin
        if (exp_q.size() == 0) check("extra_beat", 1, 0);
        else check($sformatf("beat%0d", beat_cnt), cur, exp_q.pop_front());
        beat_cnt++;
        last_xfer_cyc = cyc;
      end
      if (core_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end else begin
      hold_pend = 1'b0;
    end
  end

  // ---------------- drivers ----------------
  task automatic wr_both(input int aa, input int ad, input int wa, input int wd);
    act_wr_en = 1'b1; act_wr_addr = aa[AW-1:0]; act_wr_data = ad[BW-1:0]; act_m[aa] = ad[BW-1:0];
    wgt_wr_en = 1'b1; wgt_wr_addr = wa[WW-1:0]; wgt_wr_data = wd[BW-1:0]; wgt_m[wa] = wd[BW-1:0];
    @(posedge clk); #1;
    act_wr_en = 1'b0;
    wgt_wr_en = 1'b0;
  endtask

  task automatic start_run(input int oc, input int h, input int w, input int k, input int s,
                           output int s_cyc);
    int tic;
    tic = $urandom_range(0, 1023);
    TOTAL_IC = tic[9:0]; OC = oc[7:0]; IMG_H = h[5:0]; IMG_W = w[5:0]; K = k[2:0]; STRIDE = s[2:0];
    beat_cnt = 0; done_cnt = 0; first_valid_cyc = -1; last_xfer_cyc = -1; done_cyc = -1;
    core_start = 1'b1;
    s_cyc = cyc;
    @(posedge clk); #1;
    core_start = 1'b0;
    // Config changes after the accepted start must not matter.
    OC = 8'($urandom); IMG_H = 6'($urandom); IMG_W = 6'($urandom);
    K = 3'($urandom); STRIDE = 3'($urandom); TOTAL_IC = 10'($urandom);
    check("busy_on_start", busy, 1);
    check("total_ic_reg", dbg_total_ic, tic);
  endtask

  // rmode: 0 ready high, 1 random ready, 2 three-cycle stall at beat 2.
  task automatic run_case(input string nm, input int oc, input int h, input int w, input int k,
                          input int s, input int rmode, input bit inject);
    int s_cyc, n_exp, stall_left, t, budget;
    bit stalled;
    build_exp(oc, h, w, k, s);
    n_exp = exp_q.size();
    budget = n_exp * 8 + 40;
    mac_ready = 1'b1;
    start_run(oc, h, w, k, s, s_cyc);
    stalled = 1'b0; stall_left = 0; t = 0;
    while (done_cnt == 0 && t < budget) begin
      case (rmode)
        1: mac_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (!stalled && beat_cnt == 2) begin stall_left = 3; stalled = 1'b1; end
          mac_ready = (stall_left == 0);
          if (stall_left > 0) stall_left--;
        end
        default: mac_ready = 1'b1;
      endcase
      if (inject && t == 4) begin
        core_start = 1'b1;
        act_wr_en = 1'b1; act_wr_addr = '0; act_wr_data = ~act_m[0];
        wgt_wr_en = 1'b1; wgt_wr_addr = '0; wgt_wr_data = ~wgt_m[0];
      end else begin
        core_start = 1'b0; act_wr_en = 1'b0; wgt_wr_en = 1'b0;
      end
      @(posedge clk); #1;
      t++;
    end
    core_start = 1'b0; act_wr_en = 1'b0; wgt_wr_en = 1'b0;
    mac_ready = 1'b1;
    if (done_cnt == 0) check({nm, "_timeout"}, 0, 1);
    repeat (3) @(posedge clk);
    #1;
    check({nm, "_done_count"}, done_cnt, 1);
    check({nm, "_beats"}, beat_cnt, n_exp);
    check({nm, "_exp_left"}, exp_q.size(), 0);
    check({nm, "_busy_after"}, busy, 0);
    if (n_exp > 0) begin
      check({nm, "_first_latency"}, first_valid_cyc - s_cyc, 2);
      check({nm, "_done_after_last"}, done_cyc - last_xfer_cyc, 1);
      if (rmode == 0) check({nm, "_no_bubbles"}, last_xfer_cyc - first_valid_cyc, n_exp - 1);
    end else begin
      check({nm, "_empty_done_latency"}, done_cyc - s_cyc, 2);
    end
`ifdef PERF_CNT_EN
    if (rmode == 2) check({nm, "_perf_stall"}, perf_stall_cnt, 3);
    if (rmode == 0) check({nm, "_perf_zero"}, perf_stall_cnt, 0);
`endif
  endtask

  task automatic load_case1();
    wr_both(0, 1, 0, 5);
    wr_both(1, 2, 0, 5);
    wr_both(2, 3, 0, 5);
    wr_both(3, 4, 0, 5);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int s_cyc, rc, rh, rw, rk, rs;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", mac_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", core_done, 0);
    check("rst_beat", cur, 0);
    check("rst_state", dbg_state, 0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // K=1, stride 1, 2x2, one output channel.
    load_case1();
    run_case("k1", 1, 2, 2, 1, 1, 0, 1'b0);

    // K=3 over a 3x3 input, two output channels.
    for (int i = 0; i < 18; i++) wr_both(i, i, i, i + 10);
    run_case("k3", 2, 1, 1, 3, 1, 0, 1'b0);

    // K=1, stride 2 over a 3x3 input.
    run_case("s2", 1, 2, 2, 1, 2, 0, 1'b0);

    // Backpressure at beat 2.
    load_case1();
    run_case("stall", 1, 2, 2, 1, 1, 2, 1'b0);

    // Start and buffer writes while busy must be ignored.
    run_case("inject", 2, 1, 1, 3, 1, 0, 1'b1);
    run_case("after_inject", 1, 2, 2, 1, 1, 0, 1'b0);

    // Degenerate shapes.
    run_case("oc0", 0, 2, 2, 1, 1, 0, 1'b0);
    run_case("k0", 1, 2, 2, 0, 1, 0, 1'b0);

    // Random shapes and contents.
    for (int n = 0; n < 5; n++) begin
      for (int i = 0; i < 256; i++) wr_both(i, $urandom_range(0, 255), i & 63, $urandom_range(0, 255));
      rc = $urandom_range(1, 3); rh = $urandom_range(1, 4); rw = $urandom_range(1, 4);
      rk = $urandom_range(1, 3); rs = $urandom_range(1, 3);
      run_case($sformatf("rnd%0d", n), rc, rh, rw, rk, rs, (n == 0) ? 0 : 1, 1'b0);
    end

    // Reset in the middle of a long stream.
    build_exp(4, 4, 4, 3, 1);
    start_run(4, 4, 4, 3, 1, s_cyc);
    repeat (30) begin
      mac_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    mac_ready = 1'b1;
    resetn = 1'b0;
    #1;
    check("abort_valid", mac_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", core_done, 0);
    check("abort_state", dbg_state, 0);
    exp_q.delete();
    done_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt, 0);
    load_case1();
    run_case("post_reset", 1, 2, 2, 1, 1, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
